// File: rtl/mon_pkg.sv
// rtl/mon_pkg.sv - shared types and constants for the multiport output monitor
//
// Contents:
//   chan_state_e  per-channel receive FSM state {IDLE, RECV, FLUSH}
//   mon_result_t  result record {port, len, err}. The fields are sized for the
//                 largest legal configuration (16 ports, 16-bit byte counts),
//                 and the top level slices them down to PORT_W / LEN_W.
//   ERR_*         bit positions inside mon_result_t.err
package mon_pkg;

    localparam int MAX_PORT_W = 4;
    localparam int MAX_LEN_W  = 16;

    localparam int ERR_MISROUTE = 0;
    localparam int ERR_LEN      = 1;
    localparam int ERR_OVF      = 2;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        FLUSH
    } chan_state_e;

    typedef struct packed {
        logic [MAX_PORT_W-1:0] port;
        logic [MAX_LEN_W-1:0]  len;
        logic [2:0]            err;
    } mon_result_t;

endpackage

// File: rtl/mon_rx_channel.sv
// rtl/mon_rx_channel.sv - one receive channel: ready/read handshake, packet checks, result slot
//
// Optional feature: MON_LEN_CHECK_EN enables the header length check
// (byte 1 = payload length L, expected total L+2).
//
// Ports:
//   clock, reset_n  clock and synchronous active-low reset
//   data            byte lane of this DUT output port
//   ready           DUT has bytes available
//   read            monitor is reading (registered)
//   slot_clear      arbiter took the record this cycle
//   slot_full       result slot holds a record
//   slot_rec        the held record
module mon_rx_channel
    import mon_pkg::*;
#(
    parameter int PORT_ID   = 0,
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 64,
    parameter int PORT_W    = 2,
    parameter int LEN_W     = 7
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data,
    input  logic              ready,
    output logic              read,
    input  logic              slot_clear,
    output logic              slot_full,
    output mon_result_t       slot_rec
);

    chan_state_e      state;
    logic [LEN_W-1:0] byte_cnt;
    logic             misroute_q;
    logic             overflow_q;
    logic             len_err;
    logic [2:0]       err_bits;

    // Only the low header bits are examined when the length check is off.
    logic unused_data;
    assign unused_data = ^data;

`ifdef MON_LEN_CHECK_EN
    localparam int CMP_W = ((DATA_W > LEN_W) ? DATA_W : LEN_W) + 1;

    logic [DATA_W-1:0] len_q;

    // A runt (fewer than 2 bytes) never delivered a length byte, so it is
    // always a length error; overflowed packets report overflow only.
    always_comb begin
        len_err = !overflow_q &&
                  ((byte_cnt < LEN_W'(2)) ||
                   (CMP_W'(byte_cnt) != (CMP_W'(len_q) + CMP_W'(2))));
    end
`else
    always_comb begin
        len_err = 1'b0;
    end
`endif

    always_comb begin
        err_bits               = '0;
        err_bits[ERR_MISROUTE] = misroute_q;
        err_bits[ERR_LEN]      = len_err;
        err_bits[ERR_OVF]      = overflow_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            read       <= 1'b0;
            byte_cnt   <= '0;
            misroute_q <= 1'b0;
            overflow_q <= 1'b0;
            slot_full  <= 1'b0;
            slot_rec   <= '0;
`ifdef MON_LEN_CHECK_EN
            len_q      <= '0;
`endif
        end else begin
            // A channel only starts a packet with an empty slot, so a clear
            // and a fill can never land on the same edge.
            if (slot_clear) begin
                slot_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ready && !slot_full) begin
                        read       <= 1'b1;
                        state      <= RECV;
                        byte_cnt   <= '0;
                        misroute_q <= 1'b0;
                        overflow_q <= 1'b0;
                    end
                end
                RECV, FLUSH: begin
                    // read is always high in these states, so ready alone
                    // decides between a byte transfer and end of packet.
                    if (ready) begin
                        if (state == RECV) begin
                            if (byte_cnt == LEN_W'(MAX_BYTES)) begin
                                overflow_q <= 1'b1;
                                state      <= FLUSH;
                            end else begin
                                byte_cnt <= byte_cnt + LEN_W'(1);
                                if (byte_cnt == '0) begin
                                    misroute_q <= (data[PORT_W-1:0] != PORT_W'(PORT_ID));
                                end
`ifdef MON_LEN_CHECK_EN
                                if (byte_cnt == LEN_W'(1)) begin
                                    len_q <= data;
                                end
`endif
                            end
                        end
                    end else begin
                        read  <= 1'b0;
                        state <= IDLE;
                        if (byte_cnt != '0) begin
                            slot_full     <= 1'b1;
                            slot_rec.port <= MAX_PORT_W'(PORT_ID);
                            slot_rec.len  <= MAX_LEN_W'(byte_cnt);
                            slot_rec.err  <= err_bits;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    read  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multiport_monitor.sv
// rtl/multiport_monitor.sv - NUM_PORTS receive channels merged into one result stream
//
// Optional feature: MON_LEN_CHECK_EN (see mon_rx_channel) enables length checking.
//
// Ports:
//   clock, reset_n   clock and synchronous active-low reset
//   data_i           port p data in slice [p*DATA_W +: DATA_W]
//   ready_i, read_o  per-port ready/read handshake with the DUT
//   res_valid_o/res_ready_i  result stream handshake
//   res_port_o, res_len_o, res_err_o  result record {port, len, {ovf,len,misroute}}
//   pkt_count_o, err_count_o  saturating counts of accepted / erroneous records
module multiport_monitor
    import mon_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 64,
    parameter int PORT_W    = $clog2(NUM_PORTS),
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_PORTS*DATA_W-1:0] data_i,
    input  logic [NUM_PORTS-1:0]        ready_i,
    output logic [NUM_PORTS-1:0]        read_o,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [PORT_W-1:0]           res_port_o,
    output logic [LEN_W-1:0]            res_len_o,
    output logic [2:0]                  res_err_o,
    output logic [15:0]                 pkt_count_o,
    output logic [15:0]                 err_count_o
);

    logic [NUM_PORTS-1:0] slot_full;
    logic [NUM_PORTS-1:0] slot_clear;
    mon_result_t          slot_rec [NUM_PORTS];

    mon_result_t          res_rec_q;
    logic [PORT_W-1:0]    rr_ptr;
    logic [PORT_W-1:0]    grant_idx;
    logic [PORT_W:0]      scan_idx;
    logic                 grant_valid;
    logic                 load;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chan
        mon_rx_channel #(
            .PORT_ID   (p),
            .DATA_W    (DATA_W),
            .MAX_BYTES (MAX_BYTES),
            .PORT_W    (PORT_W),
            .LEN_W     (LEN_W)
        ) u_chan (
            .clock      (clock),
            .reset_n    (reset_n),
            .data       (data_i[p*DATA_W +: DATA_W]),
            .ready      (ready_i[p]),
            .read       (read_o[p]),
            .slot_clear (slot_clear[p]),
            .slot_full  (slot_full[p]),
            .slot_rec   (slot_rec[p])
        );
    end

    // Round-robin scan: first full slot at or after rr_ptr, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            scan_idx = {1'b0, rr_ptr} + (PORT_W+1)'(i);
            if (scan_idx >= (PORT_W+1)'(NUM_PORTS)) begin
                scan_idx = scan_idx - (PORT_W+1)'(NUM_PORTS);
            end
            if (!grant_valid && slot_full[scan_idx[PORT_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx[PORT_W-1:0];
            end
        end
    end

    assign load       = !res_valid_o || res_ready_i;
    assign slot_clear = (load && grant_valid) ? (NUM_PORTS'(1) << grant_idx) : '0;

    assign res_port_o = res_rec_q.port[PORT_W-1:0];
    assign res_len_o  = res_rec_q.len[LEN_W-1:0];
    assign res_err_o  = res_rec_q.err;

    // Record fields above PORT_W / LEN_W are always zero.
    logic unused_rec;
    assign unused_rec = ^res_rec_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            res_valid_o <= 1'b0;
            res_rec_q   <= '0;
            rr_ptr      <= '0;
            pkt_count_o <= '0;
            err_count_o <= '0;
        end else begin
            if (res_valid_o && res_ready_i) begin
                if (pkt_count_o != 16'hFFFF) begin
                    pkt_count_o <= pkt_count_o + 16'd1;
                end
                if ((|res_rec_q.err) && (err_count_o != 16'hFFFF)) begin
                    err_count_o <= err_count_o + 16'd1;
                end
            end

            // res_rec_q is untouched unless the register is free, which keeps
            // the outputs stable while the consumer stalls.
            if (load) begin
                if (grant_valid) begin
                    res_valid_o <= 1'b1;
                    res_rec_q   <= slot_rec[grant_idx];
                    rr_ptr      <= (grant_idx == PORT_W'(NUM_PORTS - 1)) ?
                                   '0 : grant_idx + PORT_W'(1);
                end else begin
                    res_valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multiport_monitor.sv
// tb/tb_multiport_monitor.sv - self-checking bench for multiport_monitor
module tb_multiport_monitor;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int MB = 64;
    localparam int PW = 2;
    localparam int LW = 7;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [NP*DW-1:0] data_i;
    logic [NP-1:0]   ready_i;
    logic [NP-1:0]   read_o;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [PW-1:0]   res_port_o;
    logic [LW-1:0]   res_len_o;
    logic [2:0]      res_err_o;
    logic [15:0]     pkt_count_o;
    logic [15:0]     err_count_o;

    always #5 clock = ~clock;

    multiport_monitor #(.NUM_PORTS(NP), .DATA_W(DW), .MAX_BYTES(MB)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .data_i      (data_i),
        .ready_i     (ready_i),
        .read_o      (read_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_port_o  (res_port_o),
        .res_len_o   (res_len_o),
        .res_err_o   (res_err_o),
        .pkt_count_o (pkt_count_o),
        .err_count_o (err_count_o)
    );

    typedef struct {
        int         len;
        logic [2:0] err;
    } exp_t;

    exp_t       expq [NP][$];
    logic [7:0] pb [NP][80];
    int         plen [NP];
    int         idx [NP];
    int         end_edge [NP];
    int         got_order [$];
    int         got_cyc [$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         pkt_exp = 0;
    int         err_exp = 0;
    int         exp_ptr = 0;
    int         last_valid_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected record comes straight from the packet rules: length clipped at
    // MAX_BYTES, header low bits vs port, optional L+2 length match.
    task automatic start_pkt(input int p, input int n, input logic [7:0] hdr, input logic [7:0] l);
        exp_t       e;
        logic       ovf;
        logic       mis;
        logic       lerr;
        logic [1:0] pp;
        for (int i = 0; i < n; i++) begin
            pb[p][i] = (i == 0) ? hdr : (i == 1) ? l : 8'($urandom);
        end
        plen[p] = n;
        idx[p]  = 0;
        pp      = 2'(p);
        ovf     = (n > MB);
        mis     = (hdr[1:0] != pp);
`ifdef MON_LEN_CHECK_EN
        lerr    = !ovf && ((n < 2) || (n != int'(l) + 2));
`else
        lerr    = 1'b0;
`endif
        e.len   = ovf ? MB : n;
        e.err   = {ovf, lerr, mis};
        expq[p].push_back(e);
    endtask

    // One clock: score any accepted record, drive the next byte on each
    // port, cross the rising edge, and account the transfers it made.
    task automatic cycle();
        logic [NP-1:0] xfer;
        int            p;
        exp_t          e;
        chk("pkt_count", 32'(pkt_count_o), 32'(pkt_exp));
        chk("err_count", 32'(err_count_o), 32'(err_exp));
        if (res_valid_o && res_ready_i) begin
            p = int'(res_port_o);
            chk("rec_pending", 32'(expq[p].size() != 0), 32'd1);
            if (expq[p].size() != 0) begin
                e = expq[p].pop_front();
                chk("rec_len", 32'(res_len_o), 32'(e.len));
                chk("rec_err", 32'(res_err_o), 32'(e.err));
            end
            got_order.push_back(p);
            got_cyc.push_back(cyc);
            last_valid_cyc = cyc;
            exp_ptr = (p + 1) % NP;
            pkt_exp++;
            if (res_err_o != 3'b000) err_exp++;
        end
        for (int q = 0; q < NP; q++) begin
            if (idx[q] < plen[q]) begin
                ready_i[q]         = 1'b1;
                data_i[q*DW +: DW] = pb[q][idx[q]];
            end else begin
                ready_i[q] = 1'b0;
            end
            if (idx[q] > 0 && idx[q] < plen[q]) begin
                chk("read_held", 32'(read_o[q]), 32'd1);
            end
            if (!ready_i[q] && read_o[q]) end_edge[q] = cyc + 1;
            xfer[q] = ready_i[q] && read_o[q];
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
        for (int q = 0; q < NP; q++) begin
            if (xfer[q]) idx[q]++;
        end
    endtask

    function automatic bit all_done();
        bit d = !res_valid_o && (read_o == '0);
        for (int q = 0; q < NP; q++) begin
            if (idx[q] < plen[q] || expq[q].size() != 0) d = 0;
        end
        return d;
    endfunction

    task automatic run(input int max);
        int k = 0;
        while (k < max && !all_done()) begin
            cycle();
            k++;
        end
        chk("run_timeout", 32'(all_done()), 32'd1);
    endtask

    task automatic wait_idle(input int p, input int max);
        int k = 0;
        while (k < max && (idx[p] < plen[p] || read_o[p])) begin
            cycle();
            k++;
        end
        chk("idle_timeout", 32'(k < max), 32'd1);
    endtask

    task automatic sim_test(input string tag);
        int base = got_order.size();
        int ptr0 = exp_ptr;
        for (int p = 0; p < NP; p++) start_pkt(p, 6, 8'(p), 8'd4);
        run(200);
        for (int i = 0; i < NP; i++) begin
            if (base + i < got_order.size()) begin
                chk({tag, "_order"}, 32'(got_order[base+i]), 32'((ptr0 + i) % NP));
                chk({tag, "_b2b"}, 32'(got_cyc[base+i]), 32'(got_cyc[base] + i));
            end else begin
                chk({tag, "_missing"}, 32'(got_order.size()), 32'(base + NP));
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        ready_i     = '0;
        data_i      = '0;
        res_ready_i = 1'b1;
        for (int p = 0; p < NP; p++) begin
            plen[p] = 0; idx[p] = 0; end_edge[p] = 0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_read", 32'(read_o), 32'd0);
        chk("rst_valid", 32'(res_valid_o), 32'd0);
        chk("rst_port", 32'(res_port_o), 32'd0);
        chk("rst_len", 32'(res_len_o), 32'd0);
        chk("rst_err", 32'(res_err_o), 32'd0);
        chk("rst_pkt", 32'(pkt_count_o), 32'd0);
        chk("rst_errc", 32'(err_count_o), 32'd0);
        reset_n = 1'b1;
        cycle();

        // all four ports end together right after reset: order 0,1,2,3
        sim_test("simA");

        // clean 5-byte packet on port 2, 2-cycle end-to-valid latency
        start_pkt(2, 5, 8'h02, 8'h03);
        run(100);
        chk("t1_latency", 32'(last_valid_cyc), 32'(end_edge[2] + 1));
        chk("t1_pkt_count", 32'(pkt_count_o), 32'(pkt_exp));

        // length mismatch on port 0
        start_pkt(0, 4, 8'h00, 8'h04);
        run(100);

        // overflow: 70 bytes clipped at 64
        start_pkt(1, 70, 8'h01, 8'd68);
        run(300);

        // misroute on port 1 (last grant port 1, pointer now 2)
        start_pkt(1, 5, 8'h03, 8'h03);
        run(100);
        chk("t2_err_count", 32'(err_count_o), 32'(err_exp));

        // rotated simultaneous order
        sim_test("simB");

        // consumer stall with port 3 slot full
        res_ready_i = 1'b0;
        start_pkt(3, 6, 8'h03, 8'h04);
        wait_idle(3, 100);
        repeat (3) cycle();
        start_pkt(3, 5, 8'h03, 8'h03);
        wait_idle(3, 100);
        repeat (2) cycle();
        start_pkt(3, 8, 8'h03, 8'h06);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_read", 32'(read_o[3]), 32'd0);
            chk("stall_valid", 32'(res_valid_o), 32'd1);
            chk("stall_port", 32'(res_port_o), 32'd3);
            chk("stall_len", 32'(res_len_o), 32'(expq[3][0].len));
            chk("stall_err", 32'(res_err_o), 32'(expq[3][0].err));
        end
        res_ready_i = 1'b1;
        run(300);

        // randomized rounds
        for (int r = 0; r < 15; r++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    int         n = $urandom_range(1, 72);
                    logic [7:0] h = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(p);
                    logic [7:0] l = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(n - 2);
                    start_pkt(p, n, h, l);
                end
            end
            run(600);
        end

        // reset mid-packet on port 0 aborts with no record
        start_pkt(0, 30, 8'h00, 8'd28);
        repeat (8) cycle();
        reset_n = 1'b0;
        ready_i = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int p = 0; p < NP; p++) begin
            plen[p] = 0; idx[p] = 0; expq[p].delete();
        end
        pkt_exp = 0;
        err_exp = 0;
        exp_ptr = 0;
        chk("mid_rst_read", 32'(read_o), 32'd0);
        chk("mid_rst_valid", 32'(res_valid_o), 32'd0);
        reset_n = 1'b1;
        repeat (10) cycle();
        chk("post_rst_valid", 32'(res_valid_o), 32'd0);
        chk("post_rst_pkt", 32'(pkt_count_o), 32'd0);
        chk("post_rst_errc", 32'(err_count_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1);
    end

endmodule
